// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus: instruction-memory request/response, execute redirect and
// the decode-side valid/ready handshake, bundled for the ifetch_queue ports.
interface ifetch_queue_if;
    // instruction memory
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // execute-stage redirect
    logic        redirect;
    logic [63:0] redirect_pc;
    // decode handshake
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    // fetch unit side
    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );

    // memory / core side
    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front-end: owns the PC, issues one-word fetches with
// credit-based flow control, and queues {pc, instr} for decode. A redirect
// flushes the queue and squashes the outstanding response.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // architectural state
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [63:0]   req_pc_q,   req_pc_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0] count_q,    count_d;
    logic [63:0]   pc_mem_q    [DEPTH];
    logic [63:0]   pc_mem_d    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];

    logic          req;
    logic          grant;
    logic          accept;
    logic          pop;
    logic [CW:0]   used;

    // Credit counts the outstanding fetch as occupied; a same-cycle pop is
    // deliberately not credited so out_ready never reaches imem_req.
    assign used   = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign req    = !reset && !bus.redirect && (used < (CW+1)'(DEPTH));
    assign grant  = req && bus.imem_gnt;
    assign accept = bus.imem_rvalid && inflight_q && !bus.redirect;
    assign pop    = (count_q != '0) && bus.out_ready;

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_instr = instr_mem_q[rd_ptr_q];
    assign bus.out_pc    = pc_mem_q[rd_ptr_q];

    // Next-state: redirect overrides everything, else grant/push/pop.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = inflight_q;
        req_pc_d    = req_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (bus.redirect) begin
            // low bits are dropped so fetches stay word aligned
            fetch_pc_d = bus.redirect_pc & ~64'h3;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
                inflight_d = 1'b1;
                req_pc_d   = fetch_pc_q;
            end else if (accept) begin
                inflight_d = 1'b0;
            end
            // credit guarantees room whenever a response is accepted
            if (accept) begin
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                instr_mem_d[wr_ptr_q] = bus.imem_rdata;
                wr_ptr_d              = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(accept) - CW'(pop);
        end
    end

    // State register with synchronous reset; storage is zeroed so the
    // head outputs read 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            req_pc_q    <= req_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: a per-cycle vector table covering reset,
// streaming, grant stalls, backpressure, redirects and mid-stream reset,
// then a hand-written fill/drain sequence.
module tb_ifetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    ifetch_queue_if bus ();

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, gnt, rdy, rd;
        logic [63:0] rpc;
        logic        inj;       // force a stray rvalid this cycle
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_v;
        logic [63:0] e_pc;
        logic        z;         // head outputs must read zero
    } vec_t;

    vec_t tv [36];

    // memory model state: grant seen in previous cycle
    logic        pend_g = 1'b0;
    logic [63:0] pend_a = '0;

    function automatic logic [31:0] tag(input logic [63:0] a);
        return a[31:0] ^ 32'h5A00_0013;
    endfunction

    function automatic vec_t mk(input logic r, g, y, d, input logic [63:0] rp,
                                input logic inj, input logic e_req,
                                input logic [63:0] e_addr, input logic e_v,
                                input logic [63:0] e_pc, input logic z);
        vec_t v;
        v.rst = r; v.gnt = g; v.rdy = y; v.rd = d; v.rpc = rp; v.inj = inj;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_pc = e_pc; v.z = z;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge (memory replies to last
    // cycle's grant), let outputs settle, record this cycle's grant.
    task automatic cycle(input logic r, g, y, d, input logic [63:0] rp, input logic inj);
        @(negedge clk);
        rst             = r;
        bus.imem_gnt    = g;
        bus.out_ready   = y;
        bus.redirect    = d;
        bus.redirect_pc = rp;
        bus.imem_rvalid = pend_g | inj;
        bus.imem_rdata  = tag(pend_a);
        #1;
        pend_g = bus.imem_req && bus.imem_gnt;
        pend_a = bus.imem_addr;
    endtask

    initial begin
        int grants;
        int npop;
        logic chk_req_next;

        bus.imem_gnt    = 1'b1;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        //              rst gnt rdy rd  rpc       inj req addr      v  pc       z
        tv[0]  = mk(1, 1, 1, 0, 64'h0,    0, 0, 64'h1000, 0, 64'h0,    1);
        tv[1]  = mk(1, 1, 1, 0, 64'h0,    0, 0, 64'h1000, 0, 64'h0,    1);
        tv[2]  = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1000, 0, 64'h0,    0);
        tv[3]  = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1004, 0, 64'h0,    0);
        tv[4]  = mk(0, 0, 1, 0, 64'h0,    0, 1, 64'h1008, 1, 64'h1000, 0);
        tv[5]  = mk(0, 0, 1, 0, 64'h0,    0, 1, 64'h1008, 1, 64'h1004, 0);
        tv[6]  = mk(0, 0, 1, 0, 64'h0,    0, 1, 64'h1008, 0, 64'h0,    0);
        tv[7]  = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1008, 0, 64'h0,    0);
        tv[8]  = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h100c, 0, 64'h0,    0);
        tv[9]  = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1010, 1, 64'h1008, 0);
        tv[10] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1014, 1, 64'h100c, 0);
        tv[11] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1018, 1, 64'h1010, 0);
        // backpressure: fill to DEPTH, then drain
        tv[12] = mk(0, 1, 0, 0, 64'h0,    0, 1, 64'h101c, 1, 64'h1014, 0);
        tv[13] = mk(0, 1, 0, 0, 64'h0,    0, 1, 64'h1020, 1, 64'h1014, 0);
        tv[14] = mk(0, 1, 0, 0, 64'h0,    0, 0, 64'h1024, 1, 64'h1014, 0);
        tv[15] = mk(0, 1, 0, 0, 64'h0,    0, 0, 64'h1024, 1, 64'h1014, 0);
        tv[16] = mk(0, 1, 1, 0, 64'h0,    0, 0, 64'h1024, 1, 64'h1014, 0);
        tv[17] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1024, 1, 64'h1018, 0);
        tv[18] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1028, 1, 64'h101c, 0);
        tv[19] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h102c, 1, 64'h1020, 0);
        tv[20] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1030, 1, 64'h1024, 0);
        // three queued + one in flight, then redirect to 0x2002
        tv[21] = mk(0, 1, 0, 0, 64'h0,    0, 1, 64'h1034, 1, 64'h1028, 0);
        tv[22] = mk(0, 1, 0, 1, 64'h2002, 0, 0, 64'h1038, 1, 64'h1028, 0);
        tv[23] = mk(0, 1, 1, 0, 64'h0,    1, 1, 64'h2000, 0, 64'h0,    0);
        tv[24] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h2004, 0, 64'h0,    0);
        tv[25] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h2008, 1, 64'h2000, 0);
        // redirect coincident with rvalid and a pop
        tv[26] = mk(0, 1, 1, 1, 64'h3000, 0, 0, 64'h200c, 1, 64'h2004, 0);
        tv[27] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h3000, 0, 64'h0,    0);
        tv[28] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h3004, 0, 64'h0,    0);
        tv[29] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h3008, 1, 64'h3000, 0);
        tv[30] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h300c, 1, 64'h3004, 0);
        // one-cycle reset with a grant outstanding, stray rvalid after
        tv[31] = mk(1, 1, 1, 0, 64'h0,    0, 0, 64'h3010, 1, 64'h3008, 0);
        tv[32] = mk(0, 1, 1, 0, 64'h0,    1, 1, 64'h1000, 0, 64'h0,    1);
        tv[33] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1004, 0, 64'h0,    0);
        tv[34] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h1008, 1, 64'h1000, 0);
        tv[35] = mk(0, 1, 1, 0, 64'h0,    0, 1, 64'h100c, 1, 64'h1004, 0);

        for (int i = 0; i < 36; i++) begin
            cycle(tv[i].rst, tv[i].gnt, tv[i].rdy, tv[i].rd, tv[i].rpc, tv[i].inj);
            chk($sformatf("c%0d imem_req", i),  64'(bus.imem_req),  64'(tv[i].e_req));
            chk($sformatf("c%0d imem_addr", i), bus.imem_addr,      tv[i].e_addr);
            chk($sformatf("c%0d out_valid", i), 64'(bus.out_valid), 64'(tv[i].e_v));
            if (tv[i].e_v) begin
                chk($sformatf("c%0d out_pc", i),    bus.out_pc,         tv[i].e_pc);
                chk($sformatf("c%0d out_instr", i), 64'(bus.out_instr), 64'(tag(tv[i].e_pc)));
            end
            if (tv[i].z) begin
                chk($sformatf("c%0d out_pc zero", i),    bus.out_pc,         64'h0);
                chk($sformatf("c%0d out_instr zero", i), 64'(bus.out_instr), 64'h0);
            end
        end

        // Fill from empty with decode stalled: exactly DEPTH grants.
        cycle(0, 1, 0, 1, 64'h4000, 0);
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0, 64'h0, 0);
            grants += int'(pend_g);
        end
        chk("fill grants", 64'(grants), 64'(DEPTH));
        chk("fill req low", 64'(bus.imem_req), 64'h0);
        chk("fill valid", 64'(bus.out_valid), 64'h1);

        // Drain: in order, no loss/dup; request returns one cycle after first pop.
        npop = 0;
        chk_req_next = 1'b0;
        for (int i = 0; i < 40 && npop < 8; i++) begin
            cycle(0, 1, 1, 0, 64'h0, 0);
            if (chk_req_next) begin
                chk("req after first pop", 64'(bus.imem_req), 64'h1);
                chk_req_next = 1'b0;
            end
            if (bus.out_valid) begin
                chk($sformatf("drain pc %0d", npop), bus.out_pc, 64'h4000 + 64'(4 * npop));
                chk($sformatf("drain instr %0d", npop), 64'(bus.out_instr),
                    64'(tag(64'h4000 + 64'(4 * npop))));
                if (npop == 0) chk_req_next = 1'b1;
                npop++;
            end
        end
        chk("drain pop count", 64'(npop), 64'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
